// File: rtl/pool_relu_stream_pkg.sv
// Shared defaults and pooling-mode encoding for the requantise / ReLU / pooling stage.
package pool_relu_stream_pkg;

    localparam int unsigned DEF_IN_WIDTH   = 24;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_SHIFT      = 8;
    localparam int unsigned DEF_OUT_COLS   = 13;
    localparam int unsigned DEF_POOL_K     = 2;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

endpackage

// File: rtl/requant_relu.sv
// Combinational requantiser: arithmetic shift, saturate to signed DATA_WIDTH, then ReLU.
module requant_relu
    import pool_relu_stream_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SHIFT      = DEF_SHIFT
) (
    input  logic signed [IN_WIDTH-1:0]   i_data,
    output logic        [DATA_WIDTH-1:0] o_relu_c
);

    localparam logic signed [IN_WIDTH-1:0] MAX_POS = IN_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);

    logic signed [IN_WIDTH-1:0] w_q;

    assign w_q = i_data >>> SHIFT;

    // Negative values clamp to zero, so only the positive saturation bound matters.
    always_comb begin
        o_relu_c = '0;
        if (!w_q[IN_WIDTH-1]) begin
            if (w_q > MAX_POS) begin
                o_relu_c = DATA_WIDTH'(MAX_POS);
            end else begin
                o_relu_c = DATA_WIDTH'(w_q);
            end
        end
    end

endmodule

// File: rtl/pool_relu_stream.sv
// Streaming requantise + ReLU + POOL_K x POOL_K max/average pooling, one pooled row per window.
module pool_relu_stream
    import pool_relu_stream_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = DEF_IN_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SHIFT      = DEF_SHIFT,
    parameter int unsigned OUT_COLS   = DEF_OUT_COLS,
    parameter int unsigned POOL_K     = DEF_POOL_K
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           mode,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [IN_WIDTH-1:0]     in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_COLS*DATA_WIDTH-1:0] out_data,
    output logic                           busy
);

    localparam int unsigned IN_COLS = OUT_COLS * POOL_K;
    localparam int unsigned LOG2K   = $clog2(POOL_K);
    localparam int unsigned AVG_SH  = 2 * LOG2K;
    localparam int unsigned ACC_W   = DATA_WIDTH + AVG_SH;
    localparam int unsigned COL_W   = $clog2(IN_COLS);
    localparam int unsigned ROW_W   = LOG2K;

    logic [COL_W-1:0]               r_col_cnt, w_col_nxt;
    logic [ROW_W-1:0]               r_row_cnt, w_row_nxt;
    logic                           r_s1_vld, r_s1_last, r_s1_first, w_s1_vld_nxt;
    logic [DATA_WIDTH-1:0]          r_s1_relu, w_relu;
    logic [COL_W-1:0]               r_s1_col, w_pcol;
    pool_mode_e                     r_mode;
    logic [ACC_W-1:0]               r_acc [OUT_COLS];
    logic [ACC_W-1:0]               w_acc_sel, w_merged;
    logic [OUT_COLS*DATA_WIDTH-1:0] r_out_data, w_out_nxt;
    logic                           r_out_valid, r_busy;
    logic                           w_stall, w_accept, w_retire, w_load;
    logic                           w_in_first, w_in_last, w_busy_nxt;

    requant_relu #(
        .IN_WIDTH   (IN_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (SHIFT)
    ) u_requant_relu (
        .i_data   (in_data),
        .o_relu_c (w_relu)
    );

    function automatic logic [DATA_WIDTH-1:0] finalise(input logic [ACC_W-1:0] a, input pool_mode_e m);
        return (m == POOL_AVG) ? DATA_WIDTH'(a >> AVG_SH) : DATA_WIDTH'(a);
    endfunction

    // Only a finished window waiting on a full output buffer may block input.
    assign w_stall    = r_s1_vld && r_s1_last && r_out_valid && !out_ready;
    assign in_ready   = !w_stall;
    assign w_accept   = in_valid && !w_stall && !clear;
    assign w_retire   = r_s1_vld && !w_stall;
    assign w_load     = !clear && w_retire && r_s1_last;
    assign w_in_first = (r_col_cnt == '0) && (r_row_cnt == '0);
    assign w_in_last  = (r_col_cnt == COL_W'(IN_COLS - 1)) && (r_row_cnt == ROW_W'(POOL_K - 1));
    assign w_pcol     = r_s1_col >> LOG2K;

    always_comb begin
        w_col_nxt = r_col_cnt;
        w_row_nxt = r_row_cnt;
        if (clear) begin
            w_col_nxt = '0;
            w_row_nxt = '0;
        end else if (w_accept) begin
            if (r_col_cnt == COL_W'(IN_COLS - 1)) begin
                w_col_nxt = '0;
                w_row_nxt = (r_row_cnt == ROW_W'(POOL_K - 1)) ? '0 : r_row_cnt + ROW_W'(1);
            end else begin
                w_col_nxt = r_col_cnt + COL_W'(1);
            end
        end
    end

    always_comb begin
        w_s1_vld_nxt = r_s1_vld;
        if (clear) begin
            w_s1_vld_nxt = 1'b0;
        end else if (w_accept) begin
            w_s1_vld_nxt = 1'b1;
        end else if (w_retire) begin
            w_s1_vld_nxt = 1'b0;
        end
        w_busy_nxt = w_s1_vld_nxt || (w_col_nxt != '0) || (w_row_nxt != '0);
    end

    // Accumulator seen by the S1 element; the first element of a window starts from zero.
    always_comb begin
        w_acc_sel = '0;
        for (int c = 0; c < OUT_COLS; c++) begin
            if (COL_W'(c) == w_pcol) begin
                w_acc_sel = r_acc[c];
            end
        end
        if (r_s1_first) begin
            w_acc_sel = '0;
        end
        if (r_mode == POOL_AVG) begin
            w_merged = w_acc_sel + ACC_W'(r_s1_relu);
        end else begin
            w_merged = (ACC_W'(r_s1_relu) > w_acc_sel) ? ACC_W'(r_s1_relu) : w_acc_sel;
        end
    end

    always_comb begin
        w_out_nxt = '0;
        for (int c = 0; c < OUT_COLS; c++) begin
            w_out_nxt[c*DATA_WIDTH +: DATA_WIDTH] =
                (COL_W'(c) == w_pcol) ? finalise(w_merged, r_mode) : finalise(r_acc[c], r_mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt   <= '0;
            r_row_cnt   <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_relu   <= '0;
            r_s1_col    <= '0;
            r_mode      <= POOL_MAX;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            for (int c = 0; c < OUT_COLS; c++) begin
                r_acc[c] <= '0;
            end
        end else begin
            r_col_cnt <= w_col_nxt;
            r_row_cnt <= w_row_nxt;
            r_s1_vld  <= w_s1_vld_nxt;
            r_busy    <= w_busy_nxt;
            if (clear) begin
                r_mode <= POOL_MAX;
                for (int c = 0; c < OUT_COLS; c++) begin
                    r_acc[c] <= '0;
                end
            end else begin
                if (w_accept) begin
                    r_s1_relu  <= w_relu;
                    r_s1_col   <= r_col_cnt;
                    r_s1_last  <= w_in_last;
                    r_s1_first <= w_in_first;
                    if (w_in_first) begin
                        r_mode <= pool_mode_e'(mode);
                    end
                end
                if (w_retire) begin
                    for (int c = 0; c < OUT_COLS; c++) begin
                        if (r_s1_last) begin
                            r_acc[c] <= '0;
                        end else if (COL_W'(c) == w_pcol) begin
                            r_acc[c] <= w_merged;
                        end
                    end
                end
            end
            if (w_load) begin
                r_out_data  <= w_out_nxt;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_pool_relu_stream.sv
// Self-checking bench for pool_relu_stream: directed scenarios plus randomized windows vs a window-level model.
module tb_pool_relu_stream;

    localparam int unsigned IW = 24;
    localparam int unsigned DW = 8;
    localparam int unsigned SH = 8;
    localparam int unsigned OC = 13;
    localparam int unsigned K  = 2;
    localparam int unsigned IC = OC * K;
    localparam int unsigned NW = IC * K;
    localparam int unsigned OW = OC * DW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clear = 1'b0;
    logic                 mode = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic signed [IW-1:0] in_data = '0;
    logic                 in_ready, out_valid, busy;
    logic [OW-1:0]        out_data;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            m_cnt   = 0;
    logic          m_mode  = 1'b0;
    int            m_win [OC];
    logic [OW-1:0] exp_q [$];
    logic [IW-1:0] wbuf [NW];
    bit            dummy;

    pool_relu_stream #(
        .IN_WIDTH (IW), .DATA_WIDTH (DW), .SHIFT (SH), .OUT_COLS (OC), .POOL_K (K)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic int quant(input logic [IW-1:0] d);
        int q;
        q = int'($signed(d)) >>> SH;
        if (q > 127) q = 127;
        if (q < 0)   q = 0;
        return q;
    endfunction

    // Window-level model: collects all K*K values per pooled column, mode taken from the first element.
    task automatic model_push(input logic [IW-1:0] d, input logic m);
        int col, r;
        logic [OW-1:0] row;
        if (m_cnt == 0) begin
            m_mode = m;
            foreach (m_win[c]) m_win[c] = 0;
        end
        col = m_cnt % IC;
        r   = quant(d);
        if (m_mode) m_win[col / K] += r;
        else if (r > m_win[col / K]) m_win[col / K] = r;
        m_cnt++;
        if (m_cnt == NW) begin
            row = '0;
            for (int c = 0; c < OC; c++) begin
                row[c*DW +: DW] = DW'(m_mode ? m_win[c] / (K * K) : m_win[c]);
            end
            exp_q.push_back(row);
            m_cnt = 0;
        end
    endtask

    task automatic step(input logic v, input logic [IW-1:0] d, input logic m, input logic clr,
                        input logic ordy, output bit acc);
        @(negedge clk);
        in_valid = v; in_data = d; mode = m; clear = clr; out_ready = ordy;
        #1;
        acc = v && in_ready && !clr;
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) check("spurious_row", out_valid, 1'b0);
            else check("row", out_data, exp_q.pop_front());
        end
        if (clr) m_cnt = 0;
        if (acc) model_push(d, m);
        @(posedge clk);
    endtask

    task automatic send(input logic [IW-1:0] d, input logic m, input bit rnd_ordy, input logic ordy);
        bit acc;
        int tries;
        acc = 0;
        tries = 0;
        while (!acc) begin
            step(1'b1, d, m, 1'b0, rnd_ordy ? ($urandom_range(0, 9) < 7) : ordy, acc);
            tries++;
            if (!acc && tries > 200) begin
                check("send_timeout", 1'b0, 1'b1);
                acc = 1;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b1, dummy);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [IW-1:0] rnd_data();
        case ($urandom_range(0, 3))
            0:       return IW'($urandom_range(0, 128 * 256));
            1:       return IW'($urandom);
            2:       return IW'(-int'($urandom_range(1, 5000)));
            default: return IW'($urandom_range(0, 40000));
        endcase
    endfunction

    initial begin
        logic [OW-1:0] ramp;
        logic [OW-1:0] held;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Max-pool ramp row, with two-edge latency
        foreach (wbuf[i]) wbuf[i] = (i < IC) ? IW'((i + 1) << 8) : '0;
        for (int i = 0; i < NW; i++) begin
            send(wbuf[i], 1'b0, 0, 1'b1);
            if (i == 3) begin
                #1 check("busy_mid", busy, 1'b1);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1 check("lat_edge1", out_valid, 1'b0);
        @(negedge clk);
        #1 check("lat_edge2", out_valid, 1'b1);
        for (int c = 0; c < OC; c++) ramp[c*DW +: DW] = DW'(2 * c + 2);
        check("ramp_row", out_data, ramp);
        drain();
        check("idle_busy", busy, 1'b0);

        // Saturation and ReLU in column 0
        foreach (wbuf[i]) wbuf[i] = '0;
        wbuf[0] = IW'(-1000); wbuf[1] = 24'h7FFF00; wbuf[IC] = 24'h000100;
        for (int i = 0; i < NW; i++) send(wbuf[i], 1'b0, 0, 1'b1);
        drain();

        // Average pooling with truncation; mode changes after the first element are ignored
        foreach (wbuf[i]) wbuf[i] = '0;
        wbuf[0] = 4 << 8;  wbuf[1] = 8 << 8;  wbuf[IC] = 12 << 8; wbuf[IC + 1] = 16 << 8;
        wbuf[2] = 1 << 8;  wbuf[3] = 1 << 8;  wbuf[IC + 2] = 1 << 8; wbuf[IC + 3] = 2 << 8;
        for (int i = 0; i < NW; i++) send(wbuf[i], (i == 0) ? 1'b1 : 1'($urandom), 0, 1'b1);
        drain();

        // Backpressure: two windows with out_ready held low
        for (int i = 0; i < NW; i++) send(rnd_data(), 1'($urandom), 0, 1'b0);
        for (int i = 0; i < NW; i++) begin
            send(rnd_data(), 1'($urandom), 0, 1'b0);
            #1 check("bp_in_ready", in_ready, (i == NW - 1) ? 1'b0 : 1'b1);
        end
        held = exp_q[0];
        for (int n = 0; n < 3; n++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b0, dummy);
            #1;
            check("bp_hold_data", out_data, held);
            check("bp_hold_ready", in_ready, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, dummy);
        #1;
        check("bp_release_valid", out_valid, 1'b1);
        check("bp_release_ready", in_ready, 1'b1);
        check("bp_second_row", out_data, exp_q[0]);
        drain();

        // clear mid-window, output buffer left intact
        for (int i = 0; i < NW; i++) send(rnd_data(), 1'b0, 0, 1'b0);
        for (int i = 0; i < 30; i++) send(rnd_data(), 1'(i / 7), 0, 1'b0);
        step(1'b1, rnd_data(), 1'b0, 1'b1, 1'b0, dummy);
        #1;
        check("clear_busy", busy, 1'b0);
        check("clear_out_valid", out_valid, 1'b1);
        check("clear_out_data", out_data, exp_q[0]);
        for (int i = 0; i < NW; i++) send(rnd_data(), (i == 0) ? 1'b1 : 1'($urandom), 0, 1'b1);
        drain();

        // Asynchronous reset mid-window while a row is pending
        for (int i = 0; i < NW; i++) send(rnd_data(), 1'($urandom), 0, 1'b0);
        for (int i = 0; i < 10; i++) send(rnd_data(), 1'($urandom), 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_data", out_data, '0);
        check("arst_busy", busy, 1'b0);
        exp_q.delete();
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NW; i++) send(rnd_data(), 1'($urandom), 0, 1'b1);
        drain();

        // Randomized windows with idle gaps and random backpressure
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < NW; i++) begin
                repeat ($urandom_range(0, 2)) step(1'b0, rnd_data(), 1'($urandom), 1'b0,
                                                   ($urandom_range(0, 9) < 7), dummy);
                send(rnd_data(), 1'($urandom), 1, 1'b0);
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
